emergency_preempt: RTL and testbench

//  Requester side of the FSM's Emergency input. Qualifies a raw siren-detector line and
//  a manual override, then drives a clean Emergency level into the traffic FSM. The level
//  has a guaranteed minimum hold, a maximum hold and a post-release cooldown lockout.

---
 rtl/emergency_preempt.sv | 142 ++++++++++++++
 tb/tb_emergency_preempt.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt.sv
// Emergency request qualifier: debounces the siren detector, merges the manual override and
// drives a clean Emergency level with minimum/maximum hold and a post-release lockout.
module emergency_preempt #(
    parameter int unsigned DEBOUNCE_CYC = 8,
    parameter int unsigned HOLD_MIN     = 16,
    parameter int unsigned HOLD_MAX     = 64,
    parameter int unsigned COOLDOWN     = 32,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       siren_det,
    input  logic       manual_req,
    input  logic       manual_clr,
    output logic       Emergency,
    output logic       lockout,
    output logic       timeout_flag,
    output logic [1:0] state_o,
    output logic [7:0] event_cnt
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StQualify  = 2'b01,
        StActive   = 2'b10,
        StCooldown = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DebLast     = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] HoldMinLast = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0] HoldMaxLast = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CoolLast    = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntSat      = '1;

    state_e           state_q, state_d;
    logic             det_meta_q, det_s_q;
    logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       event_q, event_d;
    logic             emergency_q, lockout_q;
    logic             enter_active;

    always_comb begin
        state_d      = state_q;
        q_cnt_d      = q_cnt_q;
        h_cnt_d      = h_cnt_q;
        c_cnt_d      = c_cnt_q;
        timeout_d    = timeout_q & ~manual_clr;
        enter_active = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (manual_req) begin
                    enter_active = 1'b1;
                end else if (det_s_q) begin
                    state_d = StQualify;
                    q_cnt_d = CntOne;
                end
            end
            StQualify: begin
                if (manual_req) begin
                    enter_active = 1'b1;
                end else if (!det_s_q) begin
                    state_d = StIdle;
                end else if (q_cnt_q == DebLast) begin
                    enter_active = 1'b1;
                end else begin
                    q_cnt_d = q_cnt_q + CntOne;
                end
            end
            StActive: begin
                // Exit priority: clear, manual hold, max-hold timeout, detector release.
                if (manual_clr) begin
                    state_d = StCooldown;
                    c_cnt_d = '0;
                end else if (manual_req) begin
                    h_cnt_d = (h_cnt_q == CntSat) ? h_cnt_q : h_cnt_q + CntOne;
                end else if (h_cnt_q == HoldMaxLast) begin
                    state_d   = StCooldown;
                    c_cnt_d   = '0;
                    timeout_d = 1'b1;
                end else if (!det_s_q && (h_cnt_q >= HoldMinLast)) begin
                    state_d = StCooldown;
                    c_cnt_d = '0;
                end else begin
                    h_cnt_d = (h_cnt_q == CntSat) ? h_cnt_q : h_cnt_q + CntOne;
                end
            end
            StCooldown: begin
                if (manual_req) begin
                    enter_active = 1'b1;
                end else if (c_cnt_q == CoolLast) begin
                    state_d = StIdle;
                end else begin
                    c_cnt_d = c_cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_active) begin
            state_d = StActive;
            h_cnt_d = '0;
        end
        event_d = (enter_active && (event_q != 8'hFF)) ? event_q + 8'd1 : event_q;
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            det_meta_q  <= 1'b0;
            det_s_q     <= 1'b0;
            state_q     <= StIdle;
            q_cnt_q     <= '0;
            h_cnt_q     <= '0;
            c_cnt_q     <= '0;
            timeout_q   <= 1'b0;
            event_q     <= 8'd0;
            emergency_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            det_meta_q  <= siren_det;
            det_s_q     <= det_meta_q;
            state_q     <= state_d;
            q_cnt_q     <= q_cnt_d;
            h_cnt_q     <= h_cnt_d;
            c_cnt_q     <= c_cnt_d;
            timeout_q   <= timeout_d;
            event_q     <= event_d;
            // Output flops track the next state so they always equal a decode of state_q.
            emergency_q <= (state_d == StActive);
            lockout_q   <= (state_d == StCooldown);
        end
    end

    assign Emergency    = emergency_q;
    assign lockout      = lockout_q;
    assign timeout_flag = timeout_q;
    assign state_o      = state_q;
    assign event_cnt    = event_q;

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed bench for emergency_preempt: debounce, hold limits, cooldown, manual override,
// mid-event reset and event counter saturation.
module tb_emergency_preempt;

    logic       Clk;
    logic       reset;
    logic       siren_det;
    logic       manual_req;
    logic       manual_clr;
    logic       Emergency;
    logic       lockout;
    logic       timeout_flag;
    logic [1:0] state_o;
    logic [7:0] event_cnt;

    int checks   = 0;
    int failures = 0;

    emergency_preempt dut (
        .Clk          (Clk),
        .reset        (reset),
        .siren_det    (siren_det),
        .manual_req   (manual_req),
        .manual_clr   (manual_clr),
        .Emergency    (Emergency),
        .lockout      (lockout),
        .timeout_flag (timeout_flag),
        .state_o      (state_o),
        .event_cnt    (event_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    // Advance n rising edges; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        siren_det  = 1'b0;
        manual_req = 1'b0;
        manual_clr = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        siren_det  = 1'b1;
        manual_req = 1'b1;
        manual_clr = 1'b0;
        tick(3);
        checks++;
        if ({Emergency, lockout, timeout_flag, state_o, event_cnt} !== 13'd0) begin
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d exp=all zero",
                     Emergency, lockout, timeout_flag, state_o, event_cnt);
            failures++;
        end
    endtask

    task automatic test_debounce_release();
        do_reset();
        siren_det = 1'b1;
        tick(10);
        checks++;
        if (Emergency !== 1'b0 || state_o !== 2'b01) begin
            $display("FAIL t1_edge10 got=E%b st%b exp=E0 st01", Emergency, state_o);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b1 || event_cnt !== 8'd1) begin
            $display("FAIL t1_edge11 got=E%b ev%0d exp=E1 ev1", Emergency, event_cnt);
            failures++;
        end
        tick(8);
        siren_det = 1'b0;
        tick(7);
        checks++;
        if (Emergency !== 1'b1) begin
            $display("FAIL t1_min_hold got=%b exp=1", Emergency);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b0 || lockout !== 1'b1 || state_o !== 2'b11) begin
            $display("FAIL t1_release got=E%b L%b st%b exp=E0 L1 st11", Emergency, lockout, state_o);
            failures++;
        end
        tick(31);
        checks++;
        if (lockout !== 1'b1) begin
            $display("FAIL t1_cool_last got=%b exp=1", lockout);
            failures++;
        end
        tick(1);
        checks++;
        if (lockout !== 1'b0 || state_o !== 2'b00 || timeout_flag !== 1'b0) begin
            $display("FAIL t1_idle got=L%b st%b to%b exp=L0 st00 to0", lockout, state_o, timeout_flag);
            failures++;
        end
    endtask

    task automatic test_short_glitch();
        logic seen_high;
        do_reset();
        seen_high = 1'b0;
        siren_det = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 7) siren_det = 1'b0;
            tick(1);
            seen_high = seen_high | Emergency;
        end
        checks++;
        if (state_o !== 2'b01) begin
            $display("FAIL t2_qualify got=%b exp=01", state_o);
            failures++;
        end
        tick(1);
        seen_high = seen_high | Emergency;
        checks++;
        if (state_o !== 2'b00 || seen_high !== 1'b0 || event_cnt !== 8'd0) begin
            $display("FAIL t2_abort got=st%b Eseen%b ev%0d exp=st00 Eseen0 ev0",
                     state_o, seen_high, event_cnt);
            failures++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        siren_det = 1'b1;
        tick(74);
        checks++;
        if (Emergency !== 1'b1 || timeout_flag !== 1'b0) begin
            $display("FAIL t3_hold_max got=E%b to%b exp=E1 to0", Emergency, timeout_flag);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b0 || lockout !== 1'b1 || timeout_flag !== 1'b1) begin
            $display("FAIL t3_timeout got=E%b L%b to%b exp=E0 L1 to1", Emergency, lockout, timeout_flag);
            failures++;
        end
        tick(31);
        checks++;
        if (state_o !== 2'b11) begin
            $display("FAIL t3_cool_ignores_det got=%b exp=11", state_o);
            failures++;
        end
        tick(1);
        checks++;
        if (state_o !== 2'b00) begin
            $display("FAIL t3_idle got=%b exp=00", state_o);
            failures++;
        end
        tick(1);
        checks++;
        if (state_o !== 2'b01) begin
            $display("FAIL t3_requalify got=%b exp=01", state_o);
            failures++;
        end
        tick(7);
        checks++;
        if (Emergency !== 1'b0) begin
            $display("FAIL t3_rerise_early got=%b exp=0", Emergency);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b1 || event_cnt !== 8'd2 || timeout_flag !== 1'b1) begin
            $display("FAIL t3_rerise got=E%b ev%0d to%b exp=E1 ev2 to1", Emergency, event_cnt, timeout_flag);
            failures++;
        end
        manual_clr = 1'b1;
        tick(1);
        manual_clr = 1'b0;
        siren_det  = 1'b0;
        checks++;
        if (timeout_flag !== 1'b0 || state_o !== 2'b11) begin
            $display("FAIL t3_clr got=to%b st%b exp=to0 st11", timeout_flag, state_o);
            failures++;
        end
    endtask

    task automatic test_manual();
        do_reset();
        manual_req = 1'b1;
        tick(1);
        checks++;
        if (Emergency !== 1'b1 || event_cnt !== 8'd1) begin
            $display("FAIL t4_enter got=E%b ev%0d exp=E1 ev1", Emergency, event_cnt);
            failures++;
        end
        tick(48);
        manual_clr = 1'b1;
        tick(1);
        manual_clr = 1'b0;
        checks++;
        if (state_o !== 2'b11 || Emergency !== 1'b0 || lockout !== 1'b1) begin
            $display("FAIL t4_clr got=st%b E%b L%b exp=st11 E0 L1", state_o, Emergency, lockout);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b1 || event_cnt !== 8'd2) begin
            $display("FAIL t4_reenter got=E%b ev%0d exp=E1 ev2", Emergency, event_cnt);
            failures++;
        end
        tick(79);
        checks++;
        if (Emergency !== 1'b1 || timeout_flag !== 1'b0) begin
            $display("FAIL t4_no_timeout got=E%b to%b exp=E1 to0", Emergency, timeout_flag);
            failures++;
        end
        manual_req = 1'b0;
        tick(1);
        checks++;
        if (state_o !== 2'b11 || event_cnt !== 8'd2) begin
            $display("FAIL t4_release got=st%b ev%0d exp=st11 ev2", state_o, event_cnt);
            failures++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        siren_det = 1'b1;
        tick(41);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        checks++;
        if ({Emergency, lockout, timeout_flag, state_o, event_cnt} !== 13'd0) begin
            $display("FAIL t5_reset got=%b/%b/%b/%b/%0d exp=all zero",
                     Emergency, lockout, timeout_flag, state_o, event_cnt);
            failures++;
        end
        tick(10);
        checks++;
        if (Emergency !== 1'b0) begin
            $display("FAIL t5_requal_early got=%b exp=0", Emergency);
            failures++;
        end
        tick(1);
        checks++;
        if (Emergency !== 1'b1 || event_cnt !== 8'd1) begin
            $display("FAIL t5_requal got=E%b ev%0d exp=E1 ev1", Emergency, event_cnt);
            failures++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            manual_req = 1'b1;
            manual_clr = 1'b0;
            tick(1);
            manual_req = 1'b0;
            manual_clr = 1'b1;
            tick(1);
            if (i == 254 || i == 255 || i == 300) begin
                checks++;
                if (event_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    $display("FAIL t6_event_cnt pulse=%0d got=%0d exp=%0d", i, event_cnt,
                             (i > 255) ? 255 : i);
                    failures++;
                end
            end
        end
        manual_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce_release();
        test_short_glitch();
        test_timeout();
        test_manual();
        test_mid_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
